// File: rtl/scratch_mem_arbiter_if.sv
// scratch_mem_arbiter_if: engine-side and SRAM-side bus of the scratch memory arbiter.
// The slave modport is the arbiter's view; master is the engines plus SRAM.
interface scratch_mem_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int AW = 8,
    parameter int DW = 16
);
    logic [NUM_CH-1:0] ch_en, ch_re, ch_we, ch_gnt, ch_rvalid;
    logic [NUM_CH*AW-1:0] ch_raddr0, ch_raddr1, ch_waddr;
    logic [NUM_CH*DW-1:0] ch_wdata, ch_rdata0, ch_rdata1;
    logic [AW-1:0] mem_raddr0, mem_raddr1, mem_waddr;
    logic [DW-1:0] mem_wdata, mem_rdata0, mem_rdata1;
    logic mem_re, mem_we, conflict;
    modport slave (
        input ch_en, ch_re, ch_we, ch_raddr0, ch_raddr1, ch_waddr, ch_wdata, mem_rdata0, mem_rdata1,
        output ch_gnt, ch_rvalid, ch_rdata0, ch_rdata1, mem_raddr0, mem_raddr1, mem_waddr,
        output mem_wdata, mem_re, mem_we, conflict
    );
    modport master (
        output ch_en, ch_re, ch_we, ch_raddr0, ch_raddr1, ch_waddr, ch_wdata, mem_rdata0, mem_rdata1,
        input ch_gnt, ch_rvalid, ch_rdata0, ch_rdata1, mem_raddr0, mem_raddr1, mem_waddr,
        input mem_wdata, mem_re, mem_we, conflict
    );
endinterface

// File: rtl/scratch_mem_arbiter.sv
// scratch_mem_arbiter: grants one engine exclusive use of the scratch SRAM and routes reads back.
// MEM_ARB_RR_EN selects round-robin arbitration; default is fixed priority, lowest index wins.
module scratch_mem_arbiter #(
    parameter int NUM_CH = 3,
    parameter int AW = 8,
    parameter int DW = 16,
    parameter int RD_LAT = 1
) (
    input logic clk,
    input logic rst_n,
    scratch_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NUM_CH);
    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
    state_t state, next_state;
    logic [IW-1:0] owner, win;
    logic found, grant, conflict_q;
    logic [2:0] cnt;
    logic [NUM_CH-1:0] gnt;
    logic [RD_LAT-1:0] pv;
    logic [IW-1:0] pidx [RD_LAT];
`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] cand;
    always_comb begin
        win = '0;
        found = 1'b0;
        cand = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = IW'((int'(owner) + 1 + k) % NUM_CH);
            if (!found && bus.ch_en[cand]) begin
                found = 1'b1;
                win = cand;
            end
        end
    end
`else
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && bus.ch_en[k]) begin
                found = 1'b1;
                win = IW'(k);
            end
        end
    end
`endif
    // owner doubles as the round-robin pointer, so it survives the grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= IW'(NUM_CH - 1);
            cnt <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) owner <= win;
            cnt <= (state == DRAIN) ? cnt + 3'd1 : '0;
        end
    end
    always_comb begin
        next_state = state == IDLE ? (found ? OWN : IDLE) :
                     state == OWN ? (bus.ch_en[owner] ? OWN : DRAIN) :
                     (cnt == 3'(RD_LAT - 1) ? IDLE : DRAIN);
    end
    always_comb begin
        grant = state == OWN;
        gnt = grant ? NUM_CH'(1) << owner : '0;
        bus.ch_gnt = gnt;
        bus.conflict = conflict_q;
        bus.mem_re = grant & bus.ch_re[owner];
        bus.mem_we = grant & bus.ch_we[owner];
        bus.mem_raddr0 = grant ? bus.ch_raddr0[owner*AW +: AW] : '0;
        bus.mem_raddr1 = grant ? bus.ch_raddr1[owner*AW +: AW] : '0;
        bus.mem_waddr = grant ? bus.ch_waddr[owner*AW +: AW] : '0;
        bus.mem_wdata = grant ? bus.ch_wdata[owner*DW +: DW] : '0;
    end
    // each accepted read carries its issuer through the SRAM latency
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
            conflict_q <= 1'b0;
            for (int k = 0; k < RD_LAT; k++) pidx[k] <= '0;
        end else begin
            pv[0] <= bus.mem_re;
            pidx[0] <= owner;
            for (int k = 1; k < RD_LAT; k++) begin
                pv[k] <= pv[k-1];
                pidx[k] <= pidx[k-1];
            end
            if (grant && |((bus.ch_re | bus.ch_we) & ~gnt)) conflict_q <= 1'b1;
        end
    end
    always_comb begin
        bus.ch_rvalid = '0;
        bus.ch_rdata0 = '0;
        bus.ch_rdata1 = '0;
        if (pv[RD_LAT-1]) begin
            bus.ch_rvalid[pidx[RD_LAT-1]] = 1'b1;
            bus.ch_rdata0[pidx[RD_LAT-1]*DW +: DW] = bus.mem_rdata0;
            bus.ch_rdata1[pidx[RD_LAT-1]*DW +: DW] = bus.mem_rdata1;
        end
    end
endmodule

// File: tb/tb_scratch_mem_arbiter.sv
// tb_scratch_mem_arbiter: directed plus random stimulus against a transaction-level ownership model.
// Expected reads go into a queue that a negedge monitor pops when the DUT presents ch_rvalid.
module tb_scratch_mem_arbiter;
    localparam int N = 3;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int RD_LAT = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    scratch_mem_arbiter_if #(.NUM_CH(N), .AW(AW), .DW(DW)) bus ();
    scratch_mem_arbiter #(.NUM_CH(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {int due; int ch; logic [DW-1:0] d0; logic [DW-1:0] d1;} rd_t;
    rd_t q[$];
    logic [DW-1:0] img [256];
    int cur = -1, last = N - 1, free_at = 0, edge_n = 0, tests = 0, fails = 0;
    bit conf = 1'b0, armed = 1'b0;

    function automatic logic [DW-1:0] init_val(int a);
        return DW'(a * 37 + 11);
    endfunction

    // SRAM environment model: read sees pre-write contents, data appears RD_LAT cycles later
    logic [DW-1:0] sram [256];
    logic [DW-1:0] p0 [RD_LAT];
    logic [DW-1:0] p1 [RD_LAT];
    always @(posedge clk) begin
        if (!rst_n) for (int a = 0; a < 256; a++) sram[a] <= init_val(a);
        else if (bus.mem_we) sram[bus.mem_waddr] <= bus.mem_wdata;
        p0[0] <= bus.mem_re ? sram[bus.mem_raddr0] : 16'hdead;
        p1[0] <= bus.mem_re ? sram[bus.mem_raddr1] : 16'hbeef;
        for (int k = 1; k < RD_LAT; k++) begin
            p0[k] <= p0[k-1];
            p1[k] <= p1[k-1];
        end
    end
    assign bus.mem_rdata0 = p0[RD_LAT-1];
    assign bus.mem_rdata1 = p1[RD_LAT-1];

    task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at edge %0d", name, got, exp, edge_n);
        end
    endtask

    function automatic int pick(logic [N-1:0] en, int lst);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= N; k++) if (en[(lst + k) % N]) return (lst + k) % N;
`else
        for (int k = 0; k < N; k++) if (en[k]) return k;
`endif
        return -1;
    endfunction

    // ownership model: one owner, a release blocks arbitration for RD_LAT+1 edges
    task automatic model();
        if (!rst_n) begin
            cur = -1;
            conf = 1'b0;
            q.delete();
            free_at = edge_n + 1;
            last = N - 1;
            for (int a = 0; a < 256; a++) img[a] = init_val(a);
        end else if (cur >= 0) begin
            for (int i = 0; i < N; i++) if (i != cur && (bus.ch_re[i] || bus.ch_we[i])) conf = 1'b1;
            if (bus.ch_re[cur])
                q.push_back('{edge_n + RD_LAT - 1, cur, img[bus.ch_raddr0[cur*AW +: AW]],
                              img[bus.ch_raddr1[cur*AW +: AW]]});
            if (bus.ch_we[cur]) img[bus.ch_waddr[cur*AW +: AW]] = bus.ch_wdata[cur*DW +: DW];
            if (!bus.ch_en[cur]) begin
                cur = -1;
                free_at = edge_n + RD_LAT + 1;
            end
        end else if (edge_n >= free_at && bus.ch_en != 0) begin
            cur = pick(bus.ch_en, last);
            last = cur;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        model();
        #1;
    endtask

    always @(negedge clk) begin : mon
        logic [N-1:0] eg, ev;
        logic [N*DW-1:0] e0, e1;
        logic [41:0] em;
        if (armed) begin
            eg = cur >= 0 ? N'(1) << cur : '0;
            chk("gnt", bus.ch_gnt, eg);
            chk("conflict", bus.conflict, conf);
            em = cur >= 0 ? {bus.ch_re[cur], bus.ch_we[cur], bus.ch_raddr0[cur*AW +: AW],
                             bus.ch_raddr1[cur*AW +: AW], bus.ch_waddr[cur*AW +: AW],
                             bus.ch_wdata[cur*DW +: DW]} : '0;
            chk("mem_bus", {bus.mem_re, bus.mem_we, bus.mem_raddr0, bus.mem_raddr1,
                            bus.mem_waddr, bus.mem_wdata}, em);
            if (q.size() > 0 && q[0].due == edge_n) begin
                ev = N'(1) << q[0].ch;
                e0 = '0;
                e1 = '0;
                e0[q[0].ch*DW +: DW] = q[0].d0;
                e1[q[0].ch*DW +: DW] = q[0].d1;
                chk("rvalid", bus.ch_rvalid, ev);
                chk("rdata", {bus.ch_rdata0, bus.ch_rdata1}, {e0, e1});
                void'(q.pop_front());
            end else begin
                chk("rvalid_idle", {bus.ch_rvalid, bus.ch_rdata0, bus.ch_rdata1}, '0);
            end
        end
    end

    initial begin
        bus.ch_en = '1;
        bus.ch_re = '1;
        bus.ch_we = '1;
        bus.ch_raddr0 = '0;
        bus.ch_raddr1 = '0;
        bus.ch_waddr = '0;
        bus.ch_wdata = '0;
        tick();
        armed = 1'b1;
        tick();
        chk("rst_gnt", bus.ch_gnt, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_conflict", bus.conflict, 0);
        // single owner, read and write-back
        rst_n = 1'b1;
        bus.ch_re = '0;
        bus.ch_we = '0;
        bus.ch_en = 3'b010;
        tick();
        chk("single_gnt", bus.ch_gnt, 3'b010);
        bus.ch_raddr0[AW +: AW] = 8'h05;
        bus.ch_raddr1[AW +: AW] = 8'h06;
        bus.ch_re = 3'b010;
        #1 chk("single_raddr0", bus.mem_raddr0, 8'h05);
        tick();
        bus.ch_re = '0;
        bus.ch_waddr[AW +: AW] = 8'h05;
        bus.ch_wdata[DW +: DW] = 16'h1234;
        bus.ch_we = 3'b010;
        tick();
        bus.ch_we = '0;
        bus.ch_re = 3'b010;
        tick();
        bus.ch_re = '0;
        repeat (RD_LAT) tick();
        // handoff with a read issued just before release
        bus.ch_en = '0;
        repeat (RD_LAT + 2) tick();
        bus.ch_en = 3'b001;
        repeat (2) tick();
        bus.ch_raddr0[0 +: AW] = 8'h09;
        bus.ch_re = 3'b001;
        tick();
        bus.ch_re = '0;
        bus.ch_en = 3'b100;
        tick();
        chk("handoff_drop", bus.ch_gnt, 0);
        repeat (RD_LAT) tick();
        chk("handoff_wait", bus.ch_gnt, 0);
        tick();
        chk("handoff_gnt", bus.ch_gnt, 3'b100);
        // simultaneous requests from idle
        bus.ch_en = '0;
        repeat (RD_LAT + 2) tick();
        bus.ch_en = 3'b111;
        tick();
`ifndef MEM_ARB_RR_EN
        chk("prio_first", bus.ch_gnt, 3'b001);
`endif
        bus.ch_en = 3'b110;
        repeat (RD_LAT + 2) tick();
`ifndef MEM_ARB_RR_EN
        chk("prio_second", bus.ch_gnt, 3'b010);
`endif
        // conflict from a non-owner write
        bus.ch_en = '0;
        repeat (RD_LAT + 2) tick();
        bus.ch_en = 3'b001;
        repeat (2) tick();
        bus.ch_waddr[AW +: AW] = 8'h01;
        bus.ch_wdata[DW +: DW] = 16'hffff;
        bus.ch_we = 3'b010;
        #1 chk("conf_mem_we", bus.mem_we, 0);
        tick();
        bus.ch_we = '0;
        chk("conf_set", bus.conflict, 1);
        // back-to-back reads at 1,2,3 (address 1 must be untouched by the blocked write)
        for (int a = 1; a <= 3; a++) begin
            bus.ch_raddr0[0 +: AW] = AW'(a);
            bus.ch_raddr1[0 +: AW] = AW'(a + 100);
            bus.ch_re = 3'b001;
            tick();
        end
        bus.ch_re = '0;
        repeat (RD_LAT + 1) tick();
        chk("conf_sticky", bus.conflict, 1);
        // reset with reads in flight
        bus.ch_re = 3'b001;
        tick();
        rst_n = 1'b0;
        bus.ch_re = '0;
        tick();
        rst_n = 1'b1;
        chk("conf_clear", bus.conflict, 0);
        repeat (RD_LAT + 1) tick();
        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n = $urandom_range(0, 299) != 0;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) bus.ch_en[i] = ~bus.ch_en[i];
                bus.ch_re[i] = (i == cur) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 63) == 0;
                bus.ch_we[i] = (i == cur) ? $urandom_range(0, 1) == 1 : $urandom_range(0, 63) == 0;
                bus.ch_raddr0[i*AW +: AW] = AW'($urandom_range(0, 15));
                bus.ch_raddr1[i*AW +: AW] = AW'($urandom_range(0, 15));
                bus.ch_waddr[i*AW +: AW] = AW'($urandom_range(0, 15));
                bus.ch_wdata[i*DW +: DW] = DW'($urandom);
            end
            tick();
        end
        rst_n = 1'b1;
        bus.ch_en = '0;
        bus.ch_re = '0;
        bus.ch_we = '0;
        repeat (RD_LAT + 2) tick();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL rd_drain: %0d reads outstanding, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
